// File: rtl/uart_frame_tx.sv
// UART transmitter fed from a show-ahead FIFO. It either wraps PAYLOAD_LEN characters in
// the HDR/~HDR/payload/~HDR/HDR frame or sends one FIFO character per line character (raw).
module uart_frame_tx #(
    parameter int         CLK_FREQ    = 20_000_000,
    parameter int         BAUD        = 256000,
    parameter int         DATA_BITS   = 8,
    parameter int         PARITY      = 0,
    parameter int         STOP_BITS   = 1,
    parameter int         FRAME_EN    = 1,
    parameter int         PAYLOAD_LEN = 2,
    parameter logic [7:0] HDR         = 8'h01
) (
    input  logic                 SYS_CLK,
    input  logic                 RST,
    input  logic [DATA_BITS-1:0] DATA_IN,
    input  logic                 FIFO_EMPTY,
    output logic                 RDREQ,
    output logic                 TXD,
    output logic                 BUSY,
    output logic                 FRAME_DONE
);

    localparam int                   DIV       = CLK_FREQ / BAUD;
    localparam logic [15:0]          DIV_M1    = 16'(DIV - 1);
    localparam logic [2:0]           DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]           STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic [8:0]           LAST_IDX  = 9'((FRAME_EN != 0) ? PAYLOAD_LEN + 3 : 0);
    localparam logic [8:0]           LAST_M1   = LAST_IDX - 9'd1;
    localparam logic [DATA_BITS-1:0] HDR_C     = HDR[DATA_BITS-1:0];

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t               state_reg, state_next;
    logic [15:0]          baud_cnt_reg, baud_cnt_next;
    logic [2:0]           bit_cnt_reg, bit_cnt_next;
    logic [8:0]           char_idx_reg, char_idx_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic                 parity_reg, parity_next;
    logic                 txd_reg, txd_next;
    logic                 frame_done_reg, frame_done_next;

    logic                 is_payload;
    logic [DATA_BITS-1:0] hdr_char;
    logic [DATA_BITS-1:0] load_data;
    logic                 load_parity;
    logic                 stall;
    logic                 baud_tick;

    // Slot decode: the two leading and two trailing characters of a frame are header bytes.
    always_comb begin
        is_payload = 1'b1;
        hdr_char   = HDR_C;
        if (FRAME_EN != 0) begin
            if (char_idx_reg == 9'd0 || char_idx_reg == LAST_IDX) begin
                is_payload = 1'b0;
                hdr_char   = HDR_C;
            end else if (char_idx_reg == 9'd1 || char_idx_reg == LAST_M1) begin
                is_payload = 1'b0;
                hdr_char   = ~HDR_C;
            end
        end
    end

    assign load_data   = is_payload ? DATA_IN : hdr_char;
    assign load_parity = (PARITY == 1) ? ~(^load_data) : (^load_data);
    assign stall       = is_payload && FIFO_EMPTY;
    assign baud_tick   = (baud_cnt_reg == DIV_M1);

    always_comb begin
        state_next      = state_reg;
        baud_cnt_next   = 16'd0;
        bit_cnt_next    = bit_cnt_reg;
        char_idx_next   = char_idx_reg;
        shift_next      = shift_reg;
        parity_next     = parity_reg;
        txd_next        = 1'b1;
        frame_done_next = 1'b0;
        RDREQ           = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                bit_cnt_next = 3'd0;
                if (!FIFO_EMPTY) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (!stall) begin
                    shift_next   = load_data;
                    parity_next  = load_parity;
                    RDREQ        = is_payload;
                    bit_cnt_next = 3'd0;
                    state_next   = ST_START;
                end
            end
            ST_START: begin
                txd_next      = 1'b0;
                baud_cnt_next = baud_cnt_reg + 16'd1;
                if (baud_tick) begin
                    baud_cnt_next = 16'd0;
                    state_next    = ST_DATA;
                end
            end
            ST_DATA: begin
                txd_next      = shift_reg[0];
                baud_cnt_next = baud_cnt_reg + 16'd1;
                if (baud_tick) begin
                    baud_cnt_next = 16'd0;
                    shift_next    = shift_reg >> 1;
                    if (bit_cnt_reg == DATA_LAST) begin
                        bit_cnt_next = 3'd0;
                        state_next   = (PARITY != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                txd_next      = parity_reg;
                baud_cnt_next = baud_cnt_reg + 16'd1;
                if (baud_tick) begin
                    baud_cnt_next = 16'd0;
                    bit_cnt_next  = 3'd0;
                    state_next    = ST_STOP;
                end
            end
            ST_STOP: begin
                baud_cnt_next = baud_cnt_reg + 16'd1;
                if (baud_tick) begin
                    baud_cnt_next = 16'd0;
                    if (bit_cnt_reg == STOP_LAST) begin
                        bit_cnt_next = 3'd0;
                        if (char_idx_reg == LAST_IDX) begin
                            frame_done_next = 1'b1;
                            char_idx_next   = 9'd0;
                            state_next      = ST_IDLE;
                        end else begin
                            char_idx_next = char_idx_reg + 9'd1;
                            state_next    = ST_LOAD;
                        end
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // TXD is registered, so the line lags the state register by one clock.
    always_ff @(posedge SYS_CLK or posedge RST) begin
        if (RST) begin
            state_reg      <= ST_IDLE;
            baud_cnt_reg   <= 16'd0;
            bit_cnt_reg    <= 3'd0;
            char_idx_reg   <= 9'd0;
            shift_reg      <= '0;
            parity_reg     <= 1'b0;
            txd_reg        <= 1'b1;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            baud_cnt_reg   <= baud_cnt_next;
            bit_cnt_reg    <= bit_cnt_next;
            char_idx_reg   <= char_idx_next;
            shift_reg      <= shift_next;
            parity_reg     <= parity_next;
            txd_reg        <= txd_next;
            frame_done_reg <= frame_done_next;
        end
    end

    assign TXD        = txd_reg;
    assign BUSY       = (state_reg != ST_IDLE);
    assign FRAME_DONE = frame_done_reg;

endmodule
